// File: rtl/instr_seq_pkg.sv
// Shared types and constants for the instruction frame sequencer and its response slot.
package instr_seq_pkg;

    localparam int FRAME_BEATS   = 4;
    localparam int HDR_BIT       = 1;
    localparam int RESYNC_CYCLES = 3;

    typedef enum logic [2:0] {
        ST_RESYNC,
        ST_IDLE,
        ST_SEND,
        ST_TAIL,
        ST_GAP
    } seq_state_e;

    typedef struct packed {
        logic [FRAME_BEATS-1:0][7:0] data;
        logic [FRAME_BEATS-1:0]      flags;
    } rsp_t;

endpackage

// File: rtl/instr_rsp_slot.sv
// Single-entry valid/ready holding register for one completed frame response.
module instr_rsp_slot
    import instr_seq_pkg::*;
(
    input  logic clk,
    input  logic rst,
    input  logic load,
    input  rsp_t load_rsp,
    input  logic ready,
    output logic valid,
    output rsp_t rsp
);

    // A load only happens while the slot is empty, so it never races a drain.
    always_ff @(posedge clk) begin
        if (!rst) begin
            valid <= 1'b0;
            rsp   <= '0;
        end else if (load) begin
            valid <= 1'b1;
            rsp   <= load_rsp;
        end else if (valid && ready) begin
            valid <= 1'b0;
        end
    end

endmodule

// File: rtl/instr_frame_sequencer.sv
// Turns 32-bit commands into 4-beat frames aligned to the instruction FSM cycle
// and collects the FSM's per-beat byte and flag into one response word.
module instr_frame_sequencer
    import instr_seq_pkg::*;
#(
    parameter logic [7:0] IDLE_BYTE  = 8'h00,
    parameter int         GAP_CYCLES = 0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        cmd_valid,
    input  logic [31:0] cmd_data,
    output logic        cmd_ready,
    output logic [7:0]  instr_o,
    input  logic [7:0]  fsm_instr_i,
    input  logic        fsm_flag_i,
    output logic        rsp_valid,
    output logic [31:0] rsp_data,
    output logic [3:0]  rsp_flags,
    input  logic        rsp_ready,
    output logic        busy
);

    if (IDLE_BYTE[HDR_BIT] != 1'b0) begin : g_bad_idle
        $error("IDLE_BYTE must keep the header bit clear");
    end
    if (GAP_CYCLES < 0 || GAP_CYCLES > 15) begin : g_bad_gap
        $error("GAP_CYCLES must be within 0..15");
    end

    localparam logic [1:0] LAST_BEAT = 2'(FRAME_BEATS - 1);
    localparam logic [7:0] HDR_MASK  = 8'(1) << HDR_BIT;

    seq_state_e                  state, state_d;
    logic [3:0]                  cnt;
    logic [1:0]                  beat;
    logic [FRAME_BEATS-2:0][7:0] cmd_q;       // beats 1..3, shifted out byte by byte
    logic [FRAME_BEATS-1:0][7:0] acc_data;
    logic [FRAME_BEATS-2:0]      acc_flags;
    logic [7:0]                  instr_d;
    logic                        accept;
    logic                        load;
    rsp_t                        load_rsp;
    rsp_t                        slot_rsp;

    // state register
    always_ff @(posedge clk) begin
        if (!rst) state <= ST_RESYNC;
        else      state <= state_d;
    end

    // next-state
    always_comb begin
        state_d = state;
        case (state)
            ST_RESYNC: if (cnt == 4'(RESYNC_CYCLES - 1)) state_d = ST_IDLE;
            ST_IDLE:   if (accept) state_d = ST_SEND;
            ST_SEND:   if (beat == LAST_BEAT) state_d = ST_TAIL;
            ST_TAIL:   state_d = (GAP_CYCLES > 0) ? ST_GAP : ST_IDLE;
            ST_GAP:    if (cnt == 4'd0) state_d = ST_IDLE;
            default:   state_d = ST_RESYNC;
        endcase
    end

    // outputs; instr_d is the byte for the next cycle since instr_o is registered
    always_comb begin
        cmd_ready = (state == ST_IDLE) && !rsp_valid;
        accept    = cmd_valid && cmd_ready;
        busy      = (state != ST_IDLE);
        load      = (state == ST_TAIL);
        instr_d   = IDLE_BYTE;
        if (accept)
            instr_d = cmd_data[7:0] | HDR_MASK;
        else if (state == ST_SEND && beat != LAST_BEAT)
            instr_d = cmd_q[0];
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            cnt       <= '0;
            beat      <= '0;
            cmd_q     <= '0;
            acc_data  <= '0;
            acc_flags <= '0;
            instr_o   <= IDLE_BYTE;
        end else begin
            instr_o <= instr_d;
            case (state)
                ST_RESYNC: cnt <= (state_d == ST_IDLE) ? 4'd0 : cnt + 4'd1;
                ST_IDLE: if (accept) begin
                    cmd_q <= cmd_data[31:8];
                    beat  <= '0;
                end
                ST_SEND: begin
                    // flag for beat k arrives one cycle after beat k was driven
                    acc_data[beat] <= fsm_instr_i;
                    if (beat != 2'd0) acc_flags[beat - 2'd1] <= fsm_flag_i;
                    cmd_q <= {8'h00, cmd_q[FRAME_BEATS-2:1]};
                    beat  <= beat + 2'd1;
                end
                ST_TAIL: cnt <= 4'(GAP_CYCLES - 1);
                ST_GAP:  cnt <= cnt - 4'd1;
                default: ;
            endcase
        end
    end

    always_comb begin
        load_rsp       = '0;
        load_rsp.data  = acc_data;
        load_rsp.flags = {fsm_flag_i, acc_flags};
    end

    instr_rsp_slot u_slot (
        .clk      (clk),
        .rst      (rst),
        .load     (load),
        .load_rsp (load_rsp),
        .ready    (rsp_ready),
        .valid    (rsp_valid),
        .rsp      (slot_rsp)
    );

    assign rsp_data  = slot_rsp.data;
    assign rsp_flags = slot_rsp.flags;

endmodule
